// File: rtl/rle_packet_uart_scheduler.sv
// Round-robin scheduler that shares one UART transmitter between the Y/U/V RLE
// packet builders, stamping a wrapping packet ID into byte 0 of each packet.
module rle_packet_uart_scheduler #(
  parameter int PacketLength = 6,
  parameter int IdModulo     = 255
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [2:0]                i_req,
  input  logic [8*PacketLength-1:0] i_pkt_y,
  input  logic [8*PacketLength-1:0] i_pkt_u,
  input  logic [8*PacketLength-1:0] i_pkt_v,
  input  logic                      i_tx_busy,
  output logic                      o_tx_start,
  output logic [7:0]                o_tx_data,
  output logic [2:0]                o_ack,
  output logic [1:0]                o_active_ch,
  output logic                      o_busy,
  output logic [7:0]                o_next_id
);

  localparam int CntW = (PacketLength > 1) ? $clog2(PacketLength) : 1;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_HI,
    WAIT_LO,
    DONE
  } state_t;

  state_t                    state_q, state_d;
  logic [7:0]                buf_q [PacketLength];
  logic [7:0]                buf_d [PacketLength];
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic                      tx_start_q, tx_start_d;
  logic [7:0]                tx_data_q, tx_data_d;
  logic [2:0]                ack_q, ack_d;
  logic [2:0]                ack_prev_q, ack_prev_d;
  logic [1:0]                active_q, active_d;
  logic [7:0]                next_id_q, next_id_d;
  logic [1:0]                rr_q, rr_d;

  logic [2:0]                req_m;
  logic                      pick_vld;
  logic [1:0]                pick_ch;
  logic [2:0]                cand;
  logic [8*PacketLength-1:0] pick_pkt;
  logic [8:0]                id_inc;

  // A requester still holds its level during the cycle after its ack, so that
  // channel is masked for one IDLE cycle to avoid a spurious re-grant.
  always_comb begin
    req_m    = i_req & ~ack_prev_q;
    pick_vld = 1'b0;
    pick_ch  = 2'd0;
    cand     = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      cand = {1'b0, rr_q} + 3'(i);
      if (cand > 3'd2) cand = cand - 3'd3;
      if (!pick_vld && req_m[cand[1:0]]) begin
        pick_vld = 1'b1;
        pick_ch  = cand[1:0];
      end
    end
    case (pick_ch)
      2'd0:    pick_pkt = i_pkt_y;
      2'd1:    pick_pkt = i_pkt_u;
      default: pick_pkt = i_pkt_v;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    cnt_d      = cnt_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    ack_d      = '0;
    ack_prev_d = ack_q;
    active_d   = active_q;
    next_id_d  = next_id_q;
    rr_d       = rr_q;
    id_inc     = {1'b0, next_id_q} + 9'd1;

    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          for (int unsigned k = 0; k < PacketLength; k++) begin
            buf_d[k] = pick_pkt[8*(PacketLength-k)-1 -: 8];
          end
          buf_d[0] = next_id_q;
          active_d = pick_ch;
          cnt_d    = '0;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (!i_tx_busy) begin
          tx_data_d  = buf_q[cnt_q];
          tx_start_d = 1'b1;
          state_d    = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (i_tx_busy) state_d = WAIT_LO;
      end
      WAIT_LO: begin
        if (!i_tx_busy) begin
          if (cnt_q == CntW'(PacketLength - 1)) begin
            ack_d   = 3'b001 << active_q;
            state_d = DONE;
          end else begin
            cnt_d   = cnt_q + CntW'(1);
            state_d = SEND;
          end
        end
      end
      DONE: begin
        next_id_d = (id_inc == 9'(IdModulo)) ? '0 : id_inc[7:0];
        rr_d      = (active_q == 2'd2) ? 2'd0 : active_q + 2'd1;
        active_d  = 2'd3;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= IDLE;
      for (int unsigned k = 0; k < PacketLength; k++) begin
        buf_q[k] <= '0;
      end
      cnt_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      ack_q      <= '0;
      ack_prev_q <= '0;
      active_q   <= 2'd3;
      next_id_q  <= '0;
      rr_q       <= 2'd0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      cnt_q      <= cnt_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      ack_q      <= ack_d;
      ack_prev_q <= ack_prev_d;
      active_q   <= active_d;
      next_id_q  <= next_id_d;
      rr_q       <= rr_d;
    end
  end

  assign o_tx_start  = tx_start_q;
  assign o_tx_data   = tx_data_q;
  assign o_ack       = ack_q;
  assign o_active_ch = active_q;
  assign o_busy      = (state_q != IDLE);
  assign o_next_id   = next_id_q;

endmodule
